// File: rtl/pixel_assembler_pkg.sv
// rtl/pixel_assembler_pkg.sv - shared constants and FSM encoding for pixel assembly
package pixel_assembler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int PIXELS_DEFAULT = 64;
    localparam int BPP_DEFAULT    = 3;
    localparam int PIXEL_W        = 24;
    localparam int NUMBER_W       = 6;

endpackage

// File: rtl/pixel_assembler_byte_packer.sv
// rtl/pixel_assembler_byte_packer.sv - byte shift register building a G,R,B pixel word
// word_o already includes byte_i so the completing byte lands in the pixel the same edge.
module pixel_assembler_byte_packer
    import pixel_assembler_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst,
    input  logic               load_i,
    input  logic [7:0]         byte_i,
    output logic [PIXEL_W-1:0] word_o
);

    logic [PIXEL_W-1:0] shift_q;

    assign word_o = {shift_q[PIXEL_W-9:0], byte_i};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            shift_q <= '0;
        end else if (load_i) begin
            shift_q <= word_o;
        end
    end

endmodule

// File: rtl/pixel_assembler.sv
// rtl/pixel_assembler.sv - collects BPP bytes per pixel and emits indexed pixel write strobes
module pixel_assembler
    import pixel_assembler_pkg::*;
#(
    parameter int PIXELS = PIXELS_DEFAULT,
    parameter int BPP    = BPP_DEFAULT
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                frame_start,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic [NUMBER_W-1:0] number,
    output logic                EN,
    output logic [PIXEL_W-1:0]  pixel_data,
    output logic                frame_done,
    output logic                busy,
    output logic                overrun_err
);

    localparam int BCW = (BPP > 1) ? $clog2(BPP) : 1;

    state_t                state_q;
    logic [BCW-1:0]        byte_cnt_q;
    logic [NUMBER_W-1:0]   pix_cnt_q;
    logic [NUMBER_W-1:0]   number_q;
    logic [PIXEL_W-1:0]    pixel_q;
    logic                  en_q;
    logic                  frame_done_q;
    logic                  busy_q;
    logic                  overrun_q;
    logic                  byte_accept;
    logic [PIXEL_W-1:0]    packed_word;

    // frame_start always wins over a coincident byte
    assign byte_accept = (state_q == ST_COLLECT) && byte_valid && !frame_start;

    pixel_assembler_byte_packer u_packer (
        .Clk    (Clk),
        .Rst    (Rst),
        .load_i (byte_accept),
        .byte_i (byte_data),
        .word_o (packed_word)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            number_q     <= '0;
            pixel_q      <= '0;
            en_q         <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            en_q         <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_q    <= ST_COLLECT;
                        byte_cnt_q <= '0;
                        pix_cnt_q  <= '0;
                        overrun_q  <= 1'b0;
                        busy_q     <= 1'b1;
                    end else if (byte_valid) begin
                        overrun_q <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (frame_start) begin
                        byte_cnt_q <= '0;
                        pix_cnt_q  <= '0;
                        overrun_q  <= 1'b0;
                    end else if (byte_valid) begin
                        if (byte_cnt_q == BCW'(BPP - 1)) begin
                            byte_cnt_q <= '0;
                            en_q       <= 1'b1;
                            number_q   <= pix_cnt_q;
                            pixel_q    <= packed_word;
                            if (pix_cnt_q == NUMBER_W'(PIXELS - 1)) begin
                                pix_cnt_q <= '0;
                                state_q   <= ST_DONE;
                            end else begin
                                pix_cnt_q <= pix_cnt_q + NUMBER_W'(1);
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BCW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    frame_done_q <= 1'b1;
                    if (frame_start) begin
                        state_q    <= ST_COLLECT;
                        byte_cnt_q <= '0;
                        pix_cnt_q  <= '0;
                        overrun_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        if (byte_valid) begin
                            overrun_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign number      = number_q;
    assign EN          = en_q;
    assign pixel_data  = pixel_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_pixel_assembler.sv
// tb/tb_pixel_assembler.sv - directed self-checking bench for pixel_assembler
module tb_pixel_assembler;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic [5:0]  number;
    logic        EN;
    logic [23:0] pixel_data;
    logic        frame_done;
    logic        busy;
    logic        overrun_err;

    pixel_assembler dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .frame_start (frame_start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .number      (number),
        .EN          (EN),
        .pixel_data  (pixel_data),
        .frame_done  (frame_done),
        .busy        (busy),
        .overrun_err (overrun_err)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic [5:0]  en_num[$];
    logic [23:0] en_pix[$];
    int          en_cyc[$];
    int          done_cyc[$];

    always @(negedge Clk) begin
        if (EN === 1'b1) begin
            en_num.push_back(number);
            en_pix.push_back(pixel_data);
            en_cyc.push_back(cyc);
        end
        if (frame_done === 1'b1) done_cyc.push_back(cyc);
    end

    int n_tests = 0;
    int n_fail  = 0;
    int acc;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        en_num.delete();
        en_pix.delete();
        en_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        frame_start = 1'b0;
        byte_valid = 1'b0;
        tick();
        Rst = 1'b0;
        tick();
        clear_log();
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, output int acc_cyc);
        byte_valid = 1'b1;
        byte_data = b;
        tick();
        acc_cyc = cyc;
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        n_tests++;
        if ({number, EN, pixel_data, frame_done, busy, overrun_err} !== 34'd0) begin
            $display("FAIL reset_outputs: got %h expected 0",
                     {number, EN, pixel_data, frame_done, busy, overrun_err});
            n_fail++;
        end
        Rst = 1'b0;
        tick();
        clear_log();
    endtask

    task automatic test_full_frame(input bit restart_in_done);
        logic [23:0] exp_pix;
        logic [7:0]  b;
        do_reset();
        pulse_start();
        for (int i = 0; i < 192; i++) send(8'(i), acc);
        if (restart_in_done) pulse_start();
        idle(3);
        n_tests++;
        if (en_num.size() != 64) begin
            $display("FAIL full_en_count: got %0d expected 64", en_num.size());
            n_fail++;
        end else begin
            for (int k = 0; k < 64; k++) begin
                b = 8'(3 * k);
                exp_pix = {b, b + 8'd1, b + 8'd2};
                n_tests++;
                if (en_num[k] !== 6'(k) || en_pix[k] !== exp_pix) begin
                    $display("FAIL full_pixel_%0d: got num %0d pix %h expected num %0d pix %h",
                             k, en_num[k], en_pix[k], k, exp_pix);
                    n_fail++;
                end
            end
            n_tests++;
            if (en_cyc[63] !== acc) begin
                $display("FAIL full_last_latency: got cycle %0d expected %0d", en_cyc[63], acc);
                n_fail++;
            end
            n_tests++;
            if (done_cyc.size() != 1 || done_cyc[0] !== en_cyc[63] + 1) begin
                $display("FAIL full_frame_done: got %0d pulses (first cycle %0d) expected 1 at %0d",
                         done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, en_cyc[63] + 1);
                n_fail++;
            end
        end
        n_tests++;
        if (busy !== restart_in_done) begin
            $display("FAIL full_busy_after: got %b expected %b", busy, restart_in_done);
            n_fail++;
        end
        if (restart_in_done) begin
            send(8'hA1, acc);
            send(8'hA2, acc);
            send(8'hA3, acc);
            idle(2);
            n_tests++;
            if (en_num.size() != 65 || en_num[en_num.size()-1] !== 6'd0
                || en_pix[en_pix.size()-1] !== 24'hA1A2A3) begin
                $display("FAIL done_restart: got %0d ENs last pix %h expected 65 ENs last pix a1a2a3",
                         en_num.size(), (en_pix.size() > 0) ? en_pix[en_pix.size()-1] : 24'h0);
                n_fail++;
            end
        end
    endtask

    task automatic test_gappy();
        do_reset();
        pulse_start();
        send(8'h11, acc);
        idle(5);
        send(8'h22, acc);
        idle(5);
        send(8'h33, acc);
        idle(5);
        n_tests++;
        if (en_num.size() != 1 || en_num[0] !== 6'd0 || en_pix[0] !== 24'h112233
            || en_cyc[0] !== acc) begin
            $display("FAIL gappy: got %0d ENs pix %h cycle %0d expected 1 EN pix 112233 cycle %0d",
                     en_num.size(), (en_pix.size() > 0) ? en_pix[0] : 24'h0,
                     (en_cyc.size() > 0) ? en_cyc[0] : -1, acc);
            n_fail++;
        end
    endtask

    task automatic test_abort();
        do_reset();
        pulse_start();
        for (int i = 0; i < 7; i++) send(8'(i), acc);
        pulse_start();
        send(8'hAA, acc);
        send(8'hBB, acc);
        send(8'hCC, acc);
        idle(3);
        n_tests++;
        if (en_num.size() != 3) begin
            $display("FAIL abort_en_count: got %0d expected 3", en_num.size());
            n_fail++;
        end else begin
            n_tests++;
            if (en_pix[0] !== 24'h000102 || en_pix[1] !== 24'h030405 || en_num[1] !== 6'd1) begin
                $display("FAIL abort_early: got %h/%h num1 %0d expected 000102/030405 num1 1",
                         en_pix[0], en_pix[1], en_num[1]);
                n_fail++;
            end
            n_tests++;
            if (en_num[2] !== 6'd0 || en_pix[2] !== 24'hAABBCC) begin
                $display("FAIL abort_pixel: got num %0d pix %h expected num 0 pix aabbcc",
                         en_num[2], en_pix[2]);
                n_fail++;
            end
        end
        n_tests++;
        if (done_cyc.size() != 0) begin
            $display("FAIL abort_no_done: got %0d expected 0", done_cyc.size());
            n_fail++;
        end
    endtask

    task automatic test_overrun();
        do_reset();
        send(8'h77, acc);
        idle(2);
        n_tests++;
        if (overrun_err !== 1'b1 || en_num.size() != 0) begin
            $display("FAIL overrun_set: got err %b ENs %0d expected err 1 ENs 0",
                     overrun_err, en_num.size());
            n_fail++;
        end
        pulse_start();
        n_tests++;
        if (overrun_err !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL overrun_clear: got err %b busy %b expected err 0 busy 1",
                     overrun_err, busy);
            n_fail++;
        end
    endtask

    task automatic test_collision();
        do_reset();
        frame_start = 1'b1;
        byte_valid = 1'b1;
        byte_data = 8'h55;
        tick();
        frame_start = 1'b0;
        byte_valid = 1'b0;
        send(8'h01, acc);
        send(8'h02, acc);
        send(8'h03, acc);
        idle(2);
        n_tests++;
        if (en_num.size() != 1 || en_num[0] !== 6'd0 || en_pix[0] !== 24'h010203) begin
            $display("FAIL collision: got %0d ENs pix %h expected 1 EN pix 010203",
                     en_num.size(), (en_pix.size() > 0) ? en_pix[0] : 24'h0);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start();
        for (int i = 0; i < 100; i++) send(8'(i), acc);
        Rst = 1'b1;
        #1;
        clear_log();
        n_tests++;
        if ({number, EN, pixel_data, frame_done, busy, overrun_err} !== 34'd0) begin
            $display("FAIL reset_mid_outputs: got %h expected 0",
                     {number, EN, pixel_data, frame_done, busy, overrun_err});
            n_fail++;
        end
        tick();
        Rst = 1'b0;
        send(8'h10, acc);
        send(8'h20, acc);
        send(8'h30, acc);
        idle(3);
        n_tests++;
        if (en_num.size() != 0 || done_cyc.size() != 0 || overrun_err !== 1'b1) begin
            $display("FAIL reset_mid_quiet: got ENs %0d dones %0d err %b expected 0 0 1",
                     en_num.size(), done_cyc.size(), overrun_err);
            n_fail++;
        end
        pulse_start();
        send(8'h40, acc);
        send(8'h50, acc);
        send(8'h60, acc);
        idle(2);
        n_tests++;
        if (en_num.size() != 1 || en_num[0] !== 6'd0 || en_pix[0] !== 24'h405060) begin
            $display("FAIL reset_mid_resume: got %0d ENs pix %h expected 1 EN pix 405060",
                     en_num.size(), (en_pix.size() > 0) ? en_pix[0] : 24'h0);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_full_frame(1'b0);
        test_full_frame(1'b1);
        test_gappy();
        test_abort();
        test_overrun();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
